// File: rtl/regfile_pkg.sv
// Shared types and MIPS defaults for the multi-port register file.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_DEPTH  = 32;

  localparam int REG_V0 = 2;
  localparam int REG_V1 = 3;
  localparam int REG_S0 = 16;

endpackage

// File: rtl/regfile_wr_arb.sv
// Resolves the winning write port for each queried address.
// Highest-index enabled port wins; dropped zero-register writes never hit.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int ADDR_W   = 5,
  parameter int NUM_WR   = 2,
  parameter int NUM_Q    = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_Q*ADDR_W-1:0]  q_addr,
  output logic [NUM_Q-1:0]         q_hit,
  output logic [NUM_Q*DATA_W-1:0]  q_data
);

  always_comb begin
    q_hit  = '0;
    q_data = '0;
    for (int q = 0; q < NUM_Q; q++) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] &&
            wr_addr[j*ADDR_W +: ADDR_W] == q_addr[q*ADDR_W +: ADDR_W] &&
            !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == '0)) begin
          q_hit[q] = 1'b1;
          q_data[q*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with clear sweep,
// write-to-read bypass, write-port priority and debug taps.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = MIPS_DATA_W,
  parameter int DEPTH    = MIPS_DEPTH,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int TAP0_IDX = REG_V0,
  parameter int TAP1_IDX = REG_V1,
  parameter int TAP2_IDX = REG_S0
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     busy,
  output logic [DATA_W-1:0]        tap0,
  output logic [DATA_W-1:0]        tap1,
  output logic [DATA_W-1:0]        tap2
);

  localparam int NQ = NUM_RD + 3;

  state_t               state;
  state_t               state_nxt;
  logic [ADDR_W-1:0]    clr_idx;
  logic [DATA_W-1:0]    regs [DEPTH];
  logic [DATA_W-1:0]    tap_q [3];
  logic [NQ*ADDR_W-1:0] q_addr;
  logic [NQ-1:0]        q_hit;
  logic [NQ*DATA_W-1:0] q_data;
  logic                 wr_ok;

  // Read ports first, then the three tap indices.
  assign q_addr = {ADDR_W'(TAP2_IDX), ADDR_W'(TAP1_IDX),
                   ADDR_W'(TAP0_IDX), rd_addr};
  assign wr_ok  = (state == READY) && !Reset;

  regfile_wr_arb #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .NUM_WR   (NUM_WR),
    .NUM_Q    (NQ),
    .ZERO_REG (ZERO_REG)
  ) u_arb (
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .q_addr  (q_addr),
    .q_hit   (q_hit),
    .q_data  (q_data)
  );

  always_ff @(posedge Clk) begin
    if (Reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLEAR: if (clr_idx == ADDR_W'(DEPTH - 1)) state_nxt = READY;
      READY: state_nxt = READY;
    endcase
  end

  always_comb begin
    busy = (state == CLEAR);
  end

  always_ff @(posedge Clk) begin
    if (Reset)               clr_idx <= '0;
    else if (state == CLEAR) clr_idx <= clr_idx + ADDR_W'(1);
  end

  // Ascending port order: the highest enabled port lands last.
  always_ff @(posedge Clk) begin
    if (state == CLEAR) begin
      regs[clr_idx] <= '0;
    end else if (wr_ok) begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wr_en[j] &&
            !(ZERO_REG != 0 && wr_addr[j*ADDR_W +: ADDR_W] == '0))
          regs[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge Clk) begin
    for (int k = 0; k < 3; k++) begin
      if (Reset)
        tap_q[k] <= '0;
      else if (wr_ok && q_hit[NUM_RD+k])
        tap_q[k] <= q_data[(NUM_RD+k)*DATA_W +: DATA_W];
    end
  end

  assign tap0 = tap_q[0];
  assign tap1 = tap_q[1];
  assign tap2 = tap_q[2];

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (state == READY) begin
        if (ZERO_REG != 0 && rd_addr[i*ADDR_W +: ADDR_W] == '0)
          rd_data[i*DATA_W +: DATA_W] = '0;
        else if (BYPASS != 0 && q_hit[i])
          rd_data[i*DATA_W +: DATA_W] = q_data[i*DATA_W +: DATA_W];
        else
          rd_data[i*DATA_W +: DATA_W] = regs[rd_addr[i*ADDR_W +: ADDR_W]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default MIPS config).
module tb_regfile_mp;

  logic        Clk;
  logic        Reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        busy;
  logic [31:0] tap0, tap1, tap2;

  int total  = 0;
  int passed = 0;

  regfile_mp dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .tap0    (tap0),
    .tap1    (tap1),
    .tap2    (tap2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] t0;
    logic [31:0] t1;
    logic [31:0] t2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] wa0,
                       input logic [31:0] wd0, input logic [4:0] wa1,
                       input logic [31:0] wd1, input logic [4:0] ra0,
                       input logic [4:0] ra1);
    wr_en   = we;
    wr_addr = {wa1, wa0};
    wr_data = {wd1, wd0};
    rd_addr = {ra1, ra0};
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(n), 32'd32);
  endtask

  initial begin
    Reset = 1'b0;
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);

    vecs[0] = '{2'b01, 5'd2,  32'hDEADBEEF, 5'd0,  32'h0,
                5'd2,  5'd3,  32'hDEADBEEF, 32'h0,
                32'hDEADBEEF, 32'h0, 32'h0};
    vecs[1] = '{2'b00, 5'd0,  32'h0, 5'd0, 32'h0,
                5'd2,  5'd0,  32'hDEADBEEF, 32'h0,
                32'hDEADBEEF, 32'h0, 32'h0};
    vecs[2] = '{2'b11, 5'd16, 32'h1111, 5'd16, 32'h2222,
                5'd16, 5'd2,  32'h2222, 32'hDEADBEEF,
                32'hDEADBEEF, 32'h0, 32'h2222};
    vecs[3] = '{2'b00, 5'd0,  32'h0, 5'd0, 32'h0,
                5'd16, 5'd3,  32'h2222, 32'h0,
                32'hDEADBEEF, 32'h0, 32'h2222};
    vecs[4] = '{2'b11, 5'd3,  32'hA5A5, 5'd0, 32'hFFFFFFFF,
                5'd0,  5'd3,  32'h0, 32'hA5A5,
                32'hDEADBEEF, 32'hA5A5, 32'h2222};
    vecs[5] = '{2'b00, 5'd0,  32'h0, 5'd0, 32'h0,
                5'd0,  5'd3,  32'h0, 32'hA5A5,
                32'hDEADBEEF, 32'hA5A5, 32'h2222};
    vecs[6] = '{2'b11, 5'd5,  32'h55, 5'd7, 32'h77,
                5'd5,  5'd7,  32'h55, 32'h77,
                32'hDEADBEEF, 32'hA5A5, 32'h2222};
    vecs[7] = '{2'b11, 5'd2,  32'h1, 5'd2, 32'h2,
                5'd2,  5'd5,  32'h2, 32'h55,
                32'h2, 32'hA5A5, 32'h2222};
    vecs[8] = '{2'b00, 5'd0,  32'h0, 5'd0, 32'h0,
                5'd2,  5'd7,  32'h2, 32'h77,
                32'h2, 32'hA5A5, 32'h2222};

    // 1-cycle reset pulse, then idle sweep
    #2;
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("busy_after_reset", 32'(busy), 32'd1);
    check("tap0_reset", tap0, 32'h0);
    check("tap1_reset", tap1, 32'h0);
    check("tap2_reset", tap2, 32'h0);
    check("rd_clear", rd_data[31:0], 32'h0);
    count_busy("busy_cycles_first");
    check("busy_low_ready", 32'(busy), 32'd0);

    for (int i = 0; i < 16; i++) begin
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(i), 5'(i + 16));
      #1;
      check($sformatf("swept_rd%0d", i), rd_data[31:0], 32'h0);
      check($sformatf("swept_rd%0d", i + 16), rd_data[63:32], 32'h0);
    end
    check("tap0_swept", tap0, 32'h0);
    check("tap1_swept", tap1, 32'h0);
    check("tap2_swept", tap2, 32'h0);

    // Vector table: same-cycle reads, then taps after the edge
    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].we, vecs[v].wa0, vecs[v].wd0, vecs[v].wa1,
            vecs[v].wd1, vecs[v].ra0, vecs[v].ra1);
      #1;
      check($sformatf("v%0d_rd0", v), rd_data[31:0], vecs[v].e0);
      check($sformatf("v%0d_rd1", v), rd_data[63:32], vecs[v].e1);
      tick();
      check($sformatf("v%0d_tap0", v), tap0, vecs[v].t0);
      check($sformatf("v%0d_tap1", v), tap1, vecs[v].t1);
      check($sformatf("v%0d_tap2", v), tap2, vecs[v].t2);
    end

    // Reset, then reassert at sweep cycle 10 with writes active in CLEAR
    drive(2'b11, 5'd5, 32'h55, 5'd5, 32'h55, 5'd16, 5'd7);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    check("busy_mid_sweep", 32'(busy), 32'd1);
    check("rd_clear_mid0", rd_data[31:0], 32'h0);
    check("rd_clear_mid1", rd_data[63:32], 32'h0);
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    check("tap0_rereset", tap0, 32'h0);
    check("tap2_rereset", tap2, 32'h0);
    count_busy("busy_cycles_restart");
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd16);
    #1;
    check("clear_wr_dropped5", rd_data[31:0], 32'h0);
    check("old_reg16_cleared", rd_data[63:32], 32'h0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd2, 5'd7);
    #1;
    check("old_reg2_cleared", rd_data[31:0], 32'h0);
    check("old_reg7_cleared", rd_data[63:32], 32'h0);
    check("tap1_after_clear", tap1, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
